conv_window_buf: RTL and testbench

CONV_WINDOW_BUF -- requirements
Module: conv_window_buf

---
 rtl/cim_pkg.sv | 27 ++
 rtl/conv_line_fifo.sv | 27 ++
 rtl/conv_window_buf.sv | 153 +++++++++++++++
 tb/tb_conv_window_buf.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// cim_pkg: shared state type and sizing helpers for the CIM feeder blocks.
// Ports: none. Provides the window FSM state enum plus ceil-div/clog2/max1.
package cim_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } cwb_state_e;

    function automatic int cdiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int clog2i(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/conv_line_fifo.sv
// conv_line_fifo: one channel's shift line; every tap is visible in parallel.
// Ports: clk, i_shift (advance), i_data (enters tap 0), o_taps (all entries).
module conv_line_fifo #(
    parameter int DATA_SIZE   = 8,
    parameter int FIFO_LENGTH = 59
) (
    input  logic                                  clk,
    input  logic                                  i_shift,
    input  logic [DATA_SIZE-1:0]                  i_data,
    output logic [FIFO_LENGTH-1:0][DATA_SIZE-1:0] o_taps
);

    logic [FIFO_LENGTH-1:0][DATA_SIZE-1:0] r_line;

    // No reset: contents are only ever read through counter-qualified windows.
    always_ff @(posedge clk) begin
        if (i_shift) begin
            r_line[0] <= i_data;
            for (int i = 1; i < FIFO_LENGTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_taps = r_line;

endmodule

// File: rtl/conv_window_buf.sv
// conv_window_buf: streams pixels into per-channel lines and emits KxKxC windows
// as BUS_WIDTH-lane bit-plane beats. Ports: clk/rst, i_valid/i_data/o_ready in,
// o_valid/o_data/o_addr/o_last/i_ready out, o_frame_done end-of-frame pulse.
module conv_window_buf
    import cim_pkg::*;
#(
    parameter  int DATA_SIZE      = 8,
    parameter  int IMG_DIM        = 28,
    parameter  int KERNEL_DIM     = 3,
    parameter  int INPUT_CHANNELS = 2,
    parameter  int STRIDE         = 1,
    parameter  int BUS_WIDTH      = 16,
    localparam int NUM_ELEM       = INPUT_CHANNELS * KERNEL_DIM * KERNEL_DIM,
    localparam int NUM_ADDR       = cdiv(NUM_ELEM, BUS_WIDTH),
    localparam int ADDR_WIDTH     = max1(clog2i(NUM_ADDR))
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_valid,
    input  logic [INPUT_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
    output logic                                     o_ready,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic [DATA_SIZE-1:0][BUS_WIDTH-1:0]      o_data,
    output logic [ADDR_WIDTH-1:0]                    o_addr,
    output logic                                     o_last,
    output logic                                     o_frame_done
);

    localparam int K           = KERNEL_DIM;
    localparam int K2          = K * K;
    localparam int FIFO_LENGTH = IMG_DIM * (K - 1) + K;
    localparam int CNT_W       = max1(clog2i(IMG_DIM));

    localparam logic [CNT_W-1:0]      LAST_POS  = CNT_W'(IMG_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDR - 1);

    cwb_state_e            r_state;
    logic [CNT_W-1:0]      r_col;
    logic [CNT_W-1:0]      r_row;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_frame_last;
    logic                  r_frame_done;

    logic w_accept;
    logic w_beat_take;
    logic w_win_done;
    logic w_frame_end;
    logic w_last;

    logic [INPUT_CHANNELS-1:0][FIFO_LENGTH-1:0][DATA_SIZE-1:0] w_taps;
    logic [NUM_ADDR-1:0][BUS_WIDTH-1:0][DATA_SIZE-1:0]         w_win;
    logic [BUS_WIDTH-1:0][DATA_SIZE-1:0]                       w_slice;

    // A row/col position closes a window once the kernel fits and the
    // window origin lands on the stride grid.
    function automatic logic on_grid(input int pos);
        return (pos >= K - 1) && (((pos - (K - 1)) % STRIDE) == 0);
    endfunction

    assign o_ready      = (r_state == ST_FILL);
    assign o_valid      = (r_state == ST_EMIT);
    assign w_last       = (r_addr == LAST_ADDR);
    assign o_last       = o_valid && w_last;
    assign o_addr       = r_addr;
    assign o_frame_done = r_frame_done;

    assign w_accept    = i_valid && o_ready && !rst;
    assign w_beat_take = o_valid && i_ready;
    assign w_win_done  = on_grid(int'(r_col)) && on_grid(int'(r_row));
    assign w_frame_end = (r_col == LAST_POS) && (r_row == LAST_POS);

    for (genvar g = 0; g < INPUT_CHANNELS; g++) begin : g_line
        conv_line_fifo #(
            .DATA_SIZE  (DATA_SIZE),
            .FIFO_LENGTH(FIFO_LENGTH)
        ) u_line (
            .clk    (clk),
            .i_shift(w_accept),
            .i_data (i_data[g]),
            .o_taps (w_taps[g])
        );
    end

    // Tap 0 is the newest pixel, i.e. the window's bottom-right corner;
    // one image row back is IMG_DIM taps further down the line.
    for (genvar e = 0; e < NUM_ADDR * BUS_WIDTH; e++) begin : g_elem
        if (e < NUM_ELEM) begin : g_tap
            localparam int CH  = e / K2;
            localparam int KR  = (e % K2) / K;
            localparam int KC  = e % K;
            localparam int TAP = (K - 1 - KR) * IMG_DIM + (K - 1 - KC);
            assign w_win[e / BUS_WIDTH][e % BUS_WIDTH] = w_taps[CH][TAP];
        end else begin : g_pad
            assign w_win[e / BUS_WIDTH][e % BUS_WIDTH] = '0;
        end
    end

    // Lines do not shift while emitting, so the beat holds without a register.
    assign w_slice = w_win[r_addr];

    for (genvar l = 0; l < BUS_WIDTH; l++) begin : g_lane
        for (genvar b = 0; b < DATA_SIZE; b++) begin : g_plane
            assign o_data[b][l] = w_slice[l][b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_frame_last <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        if (r_col == LAST_POS) begin
                            r_col <= '0;
                            r_row <= (r_row == LAST_POS) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_win_done) begin
                            r_state      <= ST_EMIT;
                            r_addr       <= '0;
                            r_frame_last <= w_frame_end;
                        end else if (w_frame_end) begin
                            // Frame ended off the stride grid: nothing to drain.
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_beat_take) begin
                        if (w_last) begin
                            r_state      <= ST_FILL;
                            r_addr       <= '0;
                            r_frame_done <= r_frame_last;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_buf.sv
// tb_conv_window_buf: scoreboard bench for two window buffer configurations.
// DUT a: 4x4 image stride 1; DUT b: 5x5 image stride 2 (K=3, C=2, 8 lanes).
module tb_conv_window_buf;

    localparam int DS = 8;
    localparam int C  = 2;
    localparam int K  = 3;
    localparam int BW = 8;
    localparam int NE = C * K * K;
    localparam int NA = 3;
    localparam int AW = 2;

    typedef struct packed {
        logic [BW-1:0][DS-1:0] lanes;
        logic [AW-1:0]         addr;
        logic                  last;
        logic                  fd;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  i_valid      [2];
    logic [C-1:0][DS-1:0]  i_data       [2];
    logic                  o_ready      [2];
    logic                  o_valid      [2];
    logic                  i_ready      [2];
    logic [DS-1:0][BW-1:0] o_data       [2];
    logic [AW-1:0]         o_addr       [2];
    logic                  o_last       [2];
    logic                  o_frame_done [2];

    conv_window_buf #(
        .DATA_SIZE(DS), .IMG_DIM(4), .KERNEL_DIM(K),
        .INPUT_CHANNELS(C), .STRIDE(1), .BUS_WIDTH(BW)
    ) u_a (
        .clk(clk), .rst(rst), .i_valid(i_valid[0]), .i_data(i_data[0]),
        .o_ready(o_ready[0]), .o_valid(o_valid[0]), .i_ready(i_ready[0]),
        .o_data(o_data[0]), .o_addr(o_addr[0]), .o_last(o_last[0]),
        .o_frame_done(o_frame_done[0])
    );

    conv_window_buf #(
        .DATA_SIZE(DS), .IMG_DIM(5), .KERNEL_DIM(K),
        .INPUT_CHANNELS(C), .STRIDE(2), .BUS_WIDTH(BW)
    ) u_b (
        .clk(clk), .rst(rst), .i_valid(i_valid[1]), .i_data(i_data[1]),
        .o_ready(o_ready[1]), .o_valid(o_valid[1]), .i_ready(i_ready[1]),
        .o_data(o_data[1]), .o_addr(o_addr[1]), .o_last(o_last[1]),
        .o_frame_done(o_frame_done[1])
    );

    int n_chk;
    int n_fail;

    logic [DS-1:0] img [2][C][5][5];
    int            m_row [2];
    int            m_col [2];
    beat_t         q0[$];
    beat_t         q1[$];

    beat_t held       [2];
    bit    hold_v     [2];
    bit    exp_fd     [2];
    int    win_cnt    [2];
    int    fd_cnt     [2];
    int    stall_seen [2];
    int    stall_req  [2];
    int    stall_ack  [2];
    int    hold_cnt   [2];
    bit    rdy_rand   [2];

    logic [BW-1:0][DS-1:0] fw0;
    logic [BW-1:0][DS-1:0] fw2;

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endfunction

    function automatic logic [C-1:0][DS-1:0] pix(input int idx);
        logic [C-1:0][DS-1:0] p;
        p[0] = DS'(idx);
        p[1] = DS'(16 + idx);
        return p;
    endfunction

    // Image-level reference: remember each pixel at (row, col) and read the
    // window straight out of the 2-D picture when its bottom-right arrives.
    function automatic bit model_accept(input int d, input logic [C-1:0][DS-1:0] px);
        int    n, s, r, c, e;
        bit    win;
        beat_t bt;
        n = (d != 0) ? 5 : 4;
        s = (d != 0) ? 2 : 1;
        r = m_row[d];
        c = m_col[d];
        for (int ch = 0; ch < C; ch++) img[d][ch][r][c] = px[ch];
        win = (r >= K-1) && (c >= K-1) && ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
        if (win) begin
            for (int a = 0; a < NA; a++) begin
                bt = '0;
                for (int l = 0; l < BW; l++) begin
                    e = a * BW + l;
                    if (e < NE)
                        bt.lanes[l] = img[d][e/(K*K)][r-K+1+(e%(K*K))/K][c-K+1+e%K];
                end
                bt.addr = AW'(a);
                bt.last = (a == NA-1);
                bt.fd   = bt.last && (r == n-1) && (c == n-1);
                if (d == 0) q0.push_back(bt);
                else q1.push_back(bt);
            end
        end
        if (c == n-1) begin
            m_col[d] = 0;
            m_row[d] = (r == n-1) ? 0 : r + 1;
        end else begin
            m_col[d] = c + 1;
        end
        return win;
    endfunction

    function automatic void mon(input int d);
        beat_t act;
        beat_t ex;
        if (rst) begin
            hold_v[d] = 0;
            exp_fd[d] = 0;
            return;
        end
        chk("frame_done", o_frame_done[d], exp_fd[d]);
        if (o_frame_done[d]) fd_cnt[d]++;
        exp_fd[d] = 0;
        if (!o_valid[d]) begin
            if (hold_v[d]) chk("valid_dropped_in_stall", o_valid[d], 1);
            hold_v[d] = 0;
            return;
        end
        act = '0;
        for (int l = 0; l < BW; l++)
            for (int b = 0; b < DS; b++)
                act.lanes[l][b] = o_data[d][b][l];
        act.addr = o_addr[d];
        act.last = o_last[d];
        chk("ready_low_in_emit", o_ready[d], 0);
        if (hold_v[d]) begin
            chk("stall_lanes", act.lanes, held[d].lanes);
            chk("stall_addr", act.addr, held[d].addr);
        end
        if (!i_ready[d]) begin
            hold_v[d] = 1;
            held[d]   = act;
            stall_seen[d]++;
            return;
        end
        hold_v[d] = 0;
        if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: addr %0d with nothing expected", d, act.addr);
            return;
        end
        if (d == 0) ex = q0.pop_front();
        else ex = q1.pop_front();
        chk("beat_lanes", act.lanes, ex.lanes);
        chk("beat_addr", act.addr, ex.addr);
        chk("beat_last", act.last, ex.last);
        if (d == 0 && win_cnt[0] == 0 && act.addr == 0) fw0 = act.lanes;
        if (d == 0 && win_cnt[0] == 0 && act.addr == 2) fw2 = act.lanes;
        if (act.last) win_cnt[d]++;
        exp_fd[d] = ex.fd;
    endfunction

    always @(negedge clk) begin
        #2;
        mon(0);
        mon(1);
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (stall_req[d] != stall_ack[d] && o_valid[d] && o_addr[d] == 2'd1) begin
                hold_cnt[d] = 5;
                stall_ack[d]++;
            end
            if (hold_cnt[d] > 0) begin
                i_ready[d] = 1'b0;
                hold_cnt[d]--;
            end else begin
                i_ready[d] = rdy_rand[d] ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send_pixel(input int d, input logic [C-1:0][DS-1:0] px, input bit gaps);
        int t;
        bit win;
        if (gaps) begin
            i_valid[d] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        i_valid[d] = 1'b1;
        i_data[d]  = px;
        t = 0;
        while (!o_ready[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: o_ready low for %0d cycles", d, t);
            i_valid[d] = 1'b0;
            return;
        end
        win = model_accept(d, px);
        @(negedge clk);
        i_valid[d] = 1'b0;
        chk("win_latency_valid", o_valid[d], win);
        if (win) chk("win_first_addr", o_addr[d], 0);
    endtask

    task automatic drain(input int d);
        int t = 0;
        while ((((d == 0) ? q0.size() : q1.size()) != 0 || o_valid[d]) && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (t >= 400) begin
            n_fail++;
            $display("FAIL drain_timeout dut%0d: busy after %0d cycles, want idle", d, t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp0 [8];
        int exp2 [8];
        int t, base, fbase;
        exp0 = '{0, 1, 2, 4, 5, 6, 8, 9};
        exp2 = '{25, 26, 0, 0, 0, 0, 0, 0};
        n_chk  = 0;
        n_fail = 0;
        for (int d = 0; d < 2; d++) begin
            i_valid[d] = 1'b0;
            i_data[d]  = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", o_ready[d], 1);
            chk("reset_valid", o_valid[d], 0);
            chk("reset_last", o_last[d], 0);
            chk("reset_frame_done", o_frame_done[d], 0);
            chk("reset_addr", o_addr[d], 0);
        end

        for (int f = 0; f < 2; f++)
            for (int idx = 0; idx < 16; idx++)
                send_pixel(0, pix(idx), 1'b0);
        drain(0);
        chk("two_frames_windows", win_cnt[0], 8);
        chk("two_frames_done", fd_cnt[0], 2);
        for (int l = 0; l < BW; l++) begin
            chk("w0_slice0_lane", fw0[l], exp0[l]);
            chk("w0_slice2_lane", fw2[l], exp2[l]);
        end

        stall_req[0]++;
        rdy_rand[0] = 1'b1;
        for (int idx = 0; idx < 16; idx++)
            send_pixel(0, (C*DS)'($urandom), 1'b1);
        drain(0);
        rdy_rand[0] = 1'b0;
        chk("stall_cycles_seen", stall_seen[0] >= 5, 1);
        chk("rand_frame_windows", win_cnt[0], 12);
        chk("rand_frame_done", fd_cnt[0], 3);

        for (int idx = 0; idx < 11; idx++)
            send_pixel(0, pix(idx), 1'b0);
        t = 0;
        while (!(o_valid[0] && o_addr[0] == 2'd1) && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL reach_beat1: beat 1 not presented within %0d cycles", t);
        end
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_row[d] = 0;
            m_col[d] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", o_valid[0], 0);
        chk("abort_ready", o_ready[0], 1);
        chk("abort_addr", o_addr[0], 0);
        chk("abort_last", o_last[0], 0);
        base  = win_cnt[0];
        fbase = fd_cnt[0];
        for (int idx = 0; idx < 16; idx++)
            send_pixel(0, (C*DS)'($urandom), 1'b0);
        drain(0);
        chk("post_reset_windows", win_cnt[0] - base, 4);
        chk("post_reset_done", fd_cnt[0] - fbase, 1);

        rdy_rand[1] = 1'b1;
        for (int idx = 0; idx < 25; idx++)
            send_pixel(1, pix(idx), 1'b1);
        drain(1);
        chk("stride2_windows", win_cnt[1], 4);
        chk("stride2_done", fd_cnt[1], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
